// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer in front of
// the 256 x 64-bit data memory. Port 0 is the CPU load/store path, port 1 the
// DMA/debug port. Each accepted request runs as grant -> ACCESS (one memory
// strobe) -> RESP (registered read data plus a one-cycle valid pulse).
// Addresses that are misaligned or beyond the 2 KiB memory are rejected
// without touching the memory.
//
// Optional feature: define DMEM_ARB_LOCK_EN to add the p0_lock input. It lets
// port 0 hold off port 1 across several accesses (atomic read-modify-write).
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              p0_lock,
`endif
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // An address reaches the memory only if it is 8-byte aligned and lies
    // inside the 256-word (2 KiB) array.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return (addr[2:0] == 3'b000) && (addr[ADDR_W-1:11] == '0);
    endfunction

    // FSM and arbitration state
    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic              last_r;        // port granted most recently
    logic              lock_r;        // port 1 held off while set

    // Access latched at grant time
    logic              port_r;
    logic              we_r;
    logic              rej_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              rd_stb_r;
    logic              wr_stb_r;

    // Response registers
    logic              p0_rvalid_r;
    logic              p1_rvalid_r;
    logic [DATA_W-1:0] p0_rdata_r;
    logic [DATA_W-1:0] p1_rdata_r;
    logic              p0_err_r;
    logic              p1_err_r;

    // Arbitration results and the winning request
    logic              can_grant_s;
    logic              req1_eff_s;
    logic              gnt0_s;
    logic              gnt1_s;
    logic              any_gnt_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_legal_s;
    logic [DATA_W-1:0] capture_s;

    // Port 1 is masked while port 0 holds the lock; constant open otherwise.
`ifdef DMEM_ARB_LOCK_EN
    assign req1_eff_s = p1_req & ~lock_r;
`else
    assign req1_eff_s = p1_req;
`endif

    // Grants are possible only in IDLE and RESP; ACCESS is always busy.
    always_comb begin
        can_grant_s = 1'b0;
        case (state_r)
            ST_IDLE:   can_grant_s = 1'b1;
            ST_ACCESS: can_grant_s = 1'b0;
            ST_RESP:   can_grant_s = 1'b1;
            default:   can_grant_s = 1'b0;
        endcase
    end

    // Round-robin pick: on a tie the port not granted last wins.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst_n && can_grant_s) begin
            if (p0_req && req1_eff_s) begin
                if (last_r) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else if (p0_req) begin
                gnt0_s = 1'b1;
            end else if (req1_eff_s) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign any_gnt_s = gnt0_s | gnt1_s;
    assign p0_gnt    = gnt0_s;
    assign p1_gnt    = gnt1_s;

    // Select the winning port's request fields for latching.
    always_comb begin
        sel_we_s    = p0_we;
        sel_addr_s  = p0_addr;
        sel_wdata_s = p0_wdata;
        if (gnt1_s) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
        sel_legal_s = addr_legal(sel_addr_s);
    end

    // Next-state logic: RESP may chain straight into another ACCESS.
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE:   state_nx_s = any_gnt_s ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_nx_s = ST_RESP;
            ST_RESP:   state_nx_s = any_gnt_s ? ST_ACCESS : ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Data captured at the end of ACCESS: memory data for a legal read,
    // zero for writes and rejected accesses.
    always_comb begin
        capture_s = '0;
        if (we_r || rej_r) begin
            capture_s = '0;
        end else begin
            capture_s = mem_rdata;
        end
    end

    // State register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_nx_s;
            if (any_gnt_s) begin
                last_r <= gnt1_s;
            end else begin
                last_r <= last_r;
            end
        end
    end

    // Port-0 lock: follows p0_lock of each port-0 grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_r <= 1'b0;
        end else if (gnt0_s) begin
`ifdef DMEM_ARB_LOCK_EN
            lock_r <= p0_lock;
`else
            lock_r <= 1'b0;
`endif
        end else begin
            lock_r <= lock_r;
        end
    end

    // Latch the granted access; strobes are armed for the single ACCESS cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            port_r   <= 1'b0;
            we_r     <= 1'b0;
            rej_r    <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rd_stb_r <= 1'b0;
            wr_stb_r <= 1'b0;
        end else if (any_gnt_s) begin
            port_r   <= gnt1_s;
            we_r     <= sel_we_s;
            rej_r    <= ~sel_legal_s;
            addr_r   <= sel_addr_s;
            wdata_r  <= sel_wdata_s;
            rd_stb_r <= ~sel_we_s & sel_legal_s;
            wr_stb_r <= sel_we_s & sel_legal_s;
        end else begin
            rd_stb_r <= 1'b0;
            wr_stb_r <= 1'b0;
        end
    end

    // Response registers: loaded at the end of ACCESS so they present in RESP;
    // the port that does not own the response sees all zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
            p0_rdata_r  <= '0;
            p1_rdata_r  <= '0;
            p0_err_r    <= 1'b0;
            p1_err_r    <= 1'b0;
        end else if (state_r == ST_ACCESS) begin
            p0_rvalid_r <= ~port_r;
            p1_rvalid_r <= port_r;
            p0_rdata_r  <= port_r ? '0 : capture_s;
            p1_rdata_r  <= port_r ? capture_s : '0;
            p0_err_r    <= ~port_r & rej_r;
            p1_err_r    <= port_r & rej_r;
        end else begin
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
            p0_rdata_r  <= '0;
            p1_rdata_r  <= '0;
            p0_err_r    <= 1'b0;
            p1_err_r    <= 1'b0;
        end
    end

    // Strobes are forced low while reset is asserted so an abandoned ACCESS
    // can never commit a write.
    assign mem_read  = rd_stb_r & rst_n;
    assign mem_write = wr_stb_r & rst_n;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;

    assign p0_rvalid = p0_rvalid_r;
    assign p1_rvalid = p1_rvalid_r;
    assign p0_rdata  = p0_rdata_r;
    assign p1_rdata  = p1_rdata_r;
    assign p0_err    = p0_err_r;
    assign p1_err    = p1_err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by randomized
// traffic on both ports, checked by a scoreboard against a reference model
// of the arbitration rules and of the 256 x 64-bit memory.
module tb_dmem_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              p0_req, p0_we, p0_lock;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p1_req, p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p0_gnt, p0_rvalid, p0_err;
    logic              p1_gnt, p1_rvalid, p1_err;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef DMEM_ARB_LOCK_EN
        .p0_lock(p0_lock),
`endif
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory behind the arbiter (combinational read, write at posedge)
    logic [63:0] mem [256];
    assign mem_rdata = mem[mem_addr[10:3]];
    always @(posedge clk) if (mem_write) mem[mem_addr[10:3]] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        lock;
    } op_t;

    typedef struct {
        logic        port;
        logic [63:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];
    int   glog_port[$];
    int   glog_cyc[$];

    // Reference model state
    logic [63:0] ref_mem [256];
    logic        mlast = 1'b1;
    logic        mlock = 1'b0;
    logic        prev_gnt = 1'b0;
    logic        exp_rd = 1'b0, exp_wr = 1'b0;
    logic [63:0] exp_addr = 64'd0, exp_wdata = 64'd0;
    logic        g0_seen = 1'b0, g1_seen = 1'b0;
    logic        random_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic op_t mk(input logic we, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic lock);
        op_t o;
        o.we = we; o.addr = addr; o.wdata = wdata; o.lock = lock;
        return o;
    endfunction

    function automatic op_t rand_op(input logic allow_lock);
        op_t o;
        int  sel;
        logic [63:0] base;
        sel    = $urandom_range(0, 9);
        base   = 64'(($urandom_range(0, 15)) * 8);
        o.we   = 1'($urandom_range(0, 1));
        o.wdata = {$urandom, $urandom};
        o.lock = allow_lock ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (sel < 7)       o.addr = base;
        else if (sel == 7) o.addr = base | 64'($urandom_range(1, 7));
        else if (sel == 8) o.addr = base | (64'd1 << $urandom_range(11, 63));
        else               o.addr = ({$urandom, $urandom} & ~64'd7) | 64'h1000;
        return o;
    endfunction

    // Drive the ports after an active edge: a granted request is consumed and
    // the next queued operation (if any) is presented.
    task automatic drive();
        op_t o;
        if (random_mode && q0.size() == 0 && !p0_req && $urandom_range(0, 2) == 0)
            q0.push_back(rand_op(1'b1));
        if (random_mode && q1.size() == 0 && !p1_req && $urandom_range(0, 2) == 0)
            q1.push_back(rand_op(1'b0));
        if (g0_seen) begin p0_req = 1'b0; p0_lock = 1'b0; end
        if (g1_seen) p1_req = 1'b0;
        if (!p0_req && q0.size() > 0) begin
            o = q0.pop_front();
            p0_req = 1'b1; p0_we = o.we; p0_addr = o.addr; p0_wdata = o.wdata; p0_lock = o.lock;
        end
        if (!p1_req && q1.size() > 0) begin
            o = q1.pop_front();
            p1_req = 1'b1; p1_we = o.we; p1_addr = o.addr; p1_wdata = o.wdata;
        end
    endtask

    // Reference model, evaluated mid-cycle: expected grants and strobes, and
    // the expected response of every grant pushed to the scoreboard.
    task automatic model_check();
        logic e0, e1, r0, r1, port, we, legal;
        logic [63:0] addr, wdata, rd;
        r0 = p0_req;
        r1 = p1_req && !mlock;
        e0 = 1'b0; e1 = 1'b0;
        if (rst_n && !prev_gnt) begin
            if (r0 && r1) begin
                e0 = mlast; e1 = !mlast;
            end else begin
                e0 = r0; e1 = r1;
            end
        end
        check("p0_gnt", 64'(p0_gnt), 64'(e0));
        check("p1_gnt", 64'(p1_gnt), 64'(e1));
        check("mem_read", 64'(mem_read), 64'(exp_rd));
        check("mem_write", 64'(mem_write), 64'(exp_wr));
        if (exp_rd || exp_wr) check("mem_addr", mem_addr, exp_addr);
        if (exp_wr) check("mem_wdata", mem_wdata, exp_wdata);
        if (p0_gnt || p1_gnt) begin
            glog_port.push_back(p1_gnt ? 1 : 0);
            glog_cyc.push_back(cyc);
        end
        exp_rd = 1'b0; exp_wr = 1'b0;
        g0_seen = e0; g1_seen = e1;
        if (!rst_n) begin
            mlast = 1'b1; mlock = 1'b0; prev_gnt = 1'b0;
        end else if (e0 || e1) begin
            port  = e1;
            we    = port ? p1_we : p0_we;
            addr  = port ? p1_addr : p0_addr;
            wdata = port ? p1_wdata : p0_wdata;
            legal = (addr % 64'd8 == 64'd0) && (addr < 64'd2048);
            rd    = (legal && !we) ? ref_mem[addr / 64'd8] : 64'd0;
            if (legal && we) ref_mem[addr / 64'd8] = wdata;
            sb.push_back('{port: port, rdata: rd, err: !legal, due: cyc + 2});
            exp_rd = legal && !we; exp_wr = legal && we;
            exp_addr = addr; exp_wdata = wdata;
            mlast = port;
`ifdef DMEM_ARB_LOCK_EN
            if (!port) mlock = p0_lock;
`endif
            prev_gnt = 1'b1;
        end else begin
            prev_gnt = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard whenever a completion pulse appears.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                vectors++; miscompares++;
                $display("FAIL rvalid_missing: got none expected port %0d at cycle %0d", sb[0].port, sb[0].due);
                void'(sb.pop_front());
            end
            if (p0_rvalid || p1_rvalid) begin
                vectors++;
                if (p0_rvalid && p1_rvalid) begin
                    miscompares++;
                    $display("FAIL rvalid_both: got both expected one (cycle %0d)", cyc);
                end else if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rvalid_spurious: got p0=%0d p1=%0d expected none (cycle %0d)", p0_rvalid, p1_rvalid, cyc);
                end else begin
                    e = sb.pop_front();
                    check("rvalid_port", 64'(p1_rvalid), 64'(e.port));
                    check("rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
                    check("err", 64'(e.port ? p1_err : p0_err), 64'(e.err));
                    check("rvalid_latency", 64'(cyc), 64'(e.due));
                end
            end
            if (!p0_rvalid) check("p0_quiet", p0_rdata | 64'(p0_err), 64'd0);
            if (!p1_rvalid) check("p1_quiet", p1_rdata | 64'(p1_err), 64'd0);
        end else begin
            check("reset_outputs", {p0_rdata | p1_rdata}
                  | 64'({p0_rvalid, p1_rvalid, p0_err, p1_err, mem_read, mem_write}), 64'd0);
        end
    end

    task automatic cycle();
        @(posedge clk); #1;
        drive();
        @(negedge clk);
        model_check();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || p0_req || p1_req || sb.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size() + q0.size() + q1.size());
        end
        cycle(); cycle();
    endtask

    task automatic check_order(input string name, input int exp_ports[$], input int spacing);
        check({name, "_count"}, 64'(glog_port.size()), 64'(exp_ports.size()));
        for (int i = 0; i < exp_ports.size() && i < glog_port.size(); i++) begin
            check({name, "_port"}, 64'(glog_port[i]), 64'(exp_ports[i]));
            if (spacing > 0 && i > 0)
                check({name, "_spacing"}, 64'(glog_cyc[i] - glog_cyc[i-1]), 64'(spacing));
        end
    endtask

    initial begin
        int diffs;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 64'd0; ref_mem[i] = 64'd0;
        end
        mem[0] = 64'd5; ref_mem[0] = 64'd5;
        rst_n = 1'b0;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 64'd0; p0_wdata = 64'hFFFF_FFFF_FFFF_FFFF; p0_lock = 1'b0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 64'd0; p1_wdata = 64'd0;

        // Reset held for three edges with a pending write on port 0
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            model_check();
            check("reset_gnt", 64'(p0_gnt), 64'd0);
            check("reset_mem_write", 64'(mem_write), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; p0_req = 1'b0;
        @(negedge clk);
        model_check();
        check("mem0_after_reset", mem[0], 64'd5);

        // Single read of word 0
        q0.push_back(mk(1'b0, 64'h0, 64'd0, 1'b0));
        drain(20);

        // Port 1 write then read back
        q1.push_back(mk(1'b1, 64'h40, 64'hDEADBEEF, 1'b0));
        q1.push_back(mk(1'b0, 64'h40, 64'd0, 1'b0));
        drain(20);

        // Contention: both ports hold two requests each
        glog_port.delete(); glog_cyc.delete();
        q0.push_back(mk(1'b0, 64'h0, 64'd0, 1'b0));
        q0.push_back(mk(1'b0, 64'h40, 64'd0, 1'b0));
        q1.push_back(mk(1'b0, 64'h8, 64'd0, 1'b0));
        q1.push_back(mk(1'b0, 64'h40, 64'd0, 1'b0));
        drain(30);
        check_order("contention", '{0, 1, 0, 1}, 2);

        // Rejections: misaligned read, out-of-range write
        q0.push_back(mk(1'b0, 64'h3, 64'd0, 1'b0));
        q1.push_back(mk(1'b1, 64'h800, 64'h1234_5678, 1'b0));
        drain(30);

`ifdef DMEM_ARB_LOCK_EN
        // Lock: port 1 waits until port 0's unlocked grant
        glog_port.delete(); glog_cyc.delete();
        q0.push_back(mk(1'b0, 64'h0, 64'd0, 1'b1));
        q0.push_back(mk(1'b1, 64'h10, 64'hA5A5, 1'b0));
        cycle();
        q1.push_back(mk(1'b0, 64'h10, 64'd0, 1'b0));
        drain(30);
        check_order("lock", '{0, 0, 1}, 0);
`endif

        // Randomized traffic on both ports
        random_mode = 1'b1;
        for (int i = 0; i < 800; i++) cycle();
        random_mode = 1'b0;
        q0.push_back(mk(1'b0, 64'h0, 64'd0, 1'b0));
        drain(200);

        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("memory_contents_diffs", 64'(diffs), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
